strip_frame_checker: RTL and testbench
======================================

STRIP_FRAME_CHECKER -- requirements
Module: strip_frame_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive good frames needed in SYNC before entering LOCKED.
REQ-002 Parameter UNLOCK_CNT, default 3: consecutive bad frames in LOCKED that force a return to HUNT.
REQ-003 Parameter TIMEOUT, default 64: maximum clk160 cycles between frame_valid pulses while in LOCKED.
REQ-004 Port clk160, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port frame_data, input, 104 bits: assembled strip frame from the upstream 4x26-bit frame assembler.
REQ-007 Port frame_valid, input, 1 bit: single-cycle qualifier for frame_data; back-to-back assertion is legal.
REQ-008 Port clear_cnt, input, 1 bit: level-sensitive synchronous clear of all statistics counters.
REQ-009 Port state, output, 2 bits: 0 = HUNT, 1 = SYNC, 2 = LOCKED; 3 is unused.
REQ-010 Port locked, output, 1 bit: high exactly when state is LOCKED.
REQ-011 Port frame_cnt, output, 32 bits: frames received while LOCKED; saturates.
REQ-012 Port err_cnt, output, 16 bits: bad frames received while LOCKED; saturates.
REQ-013 Port lost_lock_cnt, output, 8 bits: number of LOCKED-to-HUNT transitions; saturates.
REQ-014 Port err_pulse, output, 1 bit: one-cycle pulse for each bad frame received while LOCKED.
REQ-015 Port last_bad_seq, output, 8 bits: seq field of the most recent bad frame received while LOCKED.

Function
REQ-016 Frame fields: seq = frame_data[103:96]; chk = frame_data[95:88]; pay = frame_data[87:0].
REQ-017 A frame is well-formed iff chk == ~seq and pay == 11 concatenated copies of seq.
REQ-018 In HUNT, a well-formed frame loads exp_seq = seq+1, sets good_run = 1, and moves to SYNC; malformed frames are ignored.
REQ-019 In SYNC, a well-formed frame with seq == exp_seq increments good_run and advances exp_seq by 1.
REQ-020 In SYNC, when good_run reaches LOCK_CNT the block enters LOCKED on the same update.
REQ-021 In SYNC, any other frame returns the block to HUNT; lost_lock_cnt is not incremented.
REQ-022 In LOCKED, a frame is good iff it is well-formed and seq == exp_seq.
REQ-023 In LOCKED, exp_seq advances by 1 on every frame, good or bad.
REQ-024 In LOCKED, each frame increments frame_cnt.
REQ-025 In LOCKED, a bad frame increments err_cnt, asserts err_pulse, captures last_bad_seq, and increments bad_run.
REQ-026 In LOCKED, a good frame clears bad_run.
REQ-027 In LOCKED, when bad_run reaches UNLOCK_CNT: go to HUNT and increment lost_lock_cnt.
REQ-028 In LOCKED, when TIMEOUT cycles elapse with no frame_valid: go to HUNT and increment lost_lock_cnt.
REQ-029 The gap counter resets on each frame_valid and on entry to LOCKED.
REQ-030 Sequence arithmetic is modulo 256: 8'hFF is followed by 8'h00, and this is not an error.
REQ-031 All outputs are registered; state, counters, err_pulse and last_bad_seq update on the first clk160 edge after the frame_valid cycle (latency 1).
REQ-032 Saturation: counters hold at all-ones and never wrap.
REQ-033 clear_cnt zeroes frame_cnt, err_cnt and lost_lock_cnt; it does not affect state, exp_seq or the run counters.
REQ-034 When clear_cnt coincides with a counter increment, the clear wins and the counter reads 0 the next cycle.
REQ-035 When a bad-run unlock and a timeout fall on the same cycle, lost_lock_cnt increments by exactly 1.

Reset
REQ-036 While reset is high: state = HUNT, locked = 0, all counters = 0, err_pulse = 0, last_bad_seq = 0, exp_seq = 0, and good_run, bad_run and the gap counter = 0.
REQ-037 Reset overrides frame_valid and clear_cnt.
REQ-038 Asserting reset mid-frame-stream forces HUNT on the next edge; relock requires a fresh LOCK_CNT run.

Verification
REQ-039 Lock: after reset, frames with seq 0x10..0x14 sent back-to-back -> state goes HUNT, SYNC, then LOCKED one cycle after the frame with seq 0x13; frame_cnt = 1 after 0x14.
REQ-040 Wrap: locked stream with seq 0xFE, 0xFF, 0x00, 0x01 -> err_cnt stays 0 and frame_cnt increments by 4.
REQ-041 Errors: while LOCKED, one frame with pay bit 0 flipped (seq 0x22) -> err_pulse for 1 cycle, err_cnt = 1, last_bad_seq = 0x22, still LOCKED.
REQ-042 Unlock: while LOCKED, 3 consecutive frames with the wrong seq -> HUNT, lost_lock_cnt = 1, err_cnt = 3.
REQ-043 Timeout: while LOCKED, frame_valid held low for 64 cycles -> HUNT, lost_lock_cnt = 1; a gap of 63 cycles keeps LOCKED.
REQ-044 Clear/saturation: err_cnt preloaded by forcing to 0xFFFF plus one bad frame -> holds 0xFFFF; clear_cnt asserted in the same cycle as a bad frame -> err_cnt = 0.

Source files
------------

// File: rtl/strip_frame_checker.sv
// -----------------------------------------------------------------------------
// strip_frame_checker
//
// Checks the sequence/pattern integrity of 104-bit strip frames and tracks
// frame lock with a HUNT -> SYNC -> LOCKED state machine. While LOCKED it
// counts frames, bad frames and loss-of-lock events, and watches for a
// frame_valid gap longer than TIMEOUT cycles.
//
// Frame layout: seq = [103:96], chk = [95:88], pay = [87:0].
// A frame is well-formed when chk == ~seq and pay holds 11 copies of seq.
//
// Ports
//   clk160        in   rising-edge clock
//   reset         in   synchronous active-high reset
//   frame_data    in   assembled frame (104 bits)
//   frame_valid   in   single-cycle qualifier for frame_data
//   clear_cnt     in   synchronous clear of the statistics counters
//   state         out  0 = HUNT, 1 = SYNC, 2 = LOCKED
//   locked        out  high while state is LOCKED
//   frame_cnt     out  frames received while LOCKED (saturating)
//   err_cnt       out  bad frames received while LOCKED (saturating)
//   lost_lock_cnt out  LOCKED -> HUNT transitions (saturating)
//   err_pulse     out  one-cycle pulse per bad frame while LOCKED
//   last_bad_seq  out  seq of the most recent bad frame while LOCKED
// -----------------------------------------------------------------------------
module strip_frame_checker #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int TIMEOUT    = 64
) (
   input  logic         clk160,
   input  logic         reset,
   input  logic [103:0] frame_data,
   input  logic         frame_valid,
   input  logic         clear_cnt,
   output logic [1:0]   state,
   output logic         locked,
   output logic [31:0]  frame_cnt,
   output logic [15:0]  err_cnt,
   output logic [7:0]   lost_lock_cnt,
   output logic         err_pulse,
   output logic [7:0]   last_bad_seq
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [GW-1:0] LOCK_TGT   = GW'(LOCK_CNT);
   localparam logic [BW-1:0] UNLOCK_TGT = BW'(UNLOCK_CNT);
   // Last gap value before the timeout fires: a frame_valid-free cycle seen
   // with the counter at this value is the TIMEOUT-th consecutive empty one.
   localparam logic [TW-1:0] GAP_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Structural frame check: inverted-seq check byte and replicated payload.
   function automatic logic frame_well_formed(input logic [103:0] f);
      logic [7:0] s;
      s = f[103:96];
      return (f[95:88] == ~s) && (f[87:0] == {11{s}});
   endfunction

   state_t        state_r;
   state_t        next_state_s;
   logic [7:0]    exp_seq_r;
   logic [7:0]    next_exp_seq_s;
   logic [GW-1:0] good_run_r;
   logic [GW-1:0] next_good_run_s;
   logic [GW-1:0] good_inc_s;
   logic [BW-1:0] bad_run_r;
   logic [BW-1:0] next_bad_run_s;
   logic [BW-1:0] bad_inc_s;
   logic [TW-1:0] gap_r;
   logic [TW-1:0] next_gap_s;
   logic [7:0]    seq_s;
   logic          wf_s;
   logic          good_s;
   logic          frame_inc_s;
   logic          err_inc_s;
   logic          lost_inc_s;

   logic          locked_r;
   logic [31:0]   frame_cnt_r;
   logic [15:0]   err_cnt_r;
   logic [7:0]    lost_lock_cnt_r;
   logic          err_pulse_r;
   logic [7:0]    last_bad_seq_r;

   assign seq_s      = frame_data[103:96];
   assign wf_s       = frame_well_formed(frame_data);
   assign good_s     = wf_s && (seq_s == exp_seq_r);
   assign good_inc_s = good_run_r + GW'(1'b1);
   assign bad_inc_s  = bad_run_r + BW'(1'b1);

   // Next-state and run/gap bookkeeping for the lock state machine.
   always_comb begin
      next_state_s    = state_r;
      next_exp_seq_s  = exp_seq_r;
      next_good_run_s = good_run_r;
      next_bad_run_s  = bad_run_r;
      next_gap_s      = gap_r;
      frame_inc_s     = 1'b0;
      err_inc_s       = 1'b0;
      lost_inc_s      = 1'b0;
      case (state_r)
         ST_HUNT: begin
            next_bad_run_s = '0;
            next_gap_s     = '0;
            if (frame_valid && wf_s) begin
               next_exp_seq_s  = seq_s + 8'd1;
               next_good_run_s = GW'(1'b1);
               // A single-frame lock requirement skips SYNC entirely.
               if (GW'(1'b1) >= LOCK_TGT) begin
                  next_state_s = ST_LOCKED;
               end else begin
                  next_state_s = ST_SYNC;
               end
            end else begin
               next_good_run_s = '0;
            end
         end
         ST_SYNC: begin
            if (frame_valid) begin
               if (good_s) begin
                  next_exp_seq_s  = exp_seq_r + 8'd1;
                  next_good_run_s = good_inc_s;
                  if (good_inc_s >= LOCK_TGT) begin
                     next_state_s   = ST_LOCKED;
                     next_bad_run_s = '0;
                     next_gap_s     = '0;
                  end else begin
                     next_state_s = ST_SYNC;
                  end
               end else begin
                  // Losing sync before lock is not a loss of lock.
                  next_state_s    = ST_HUNT;
                  next_good_run_s = '0;
               end
            end else begin
               next_state_s = ST_SYNC;
            end
         end
         ST_LOCKED: begin
            if (frame_valid) begin
               // Expected seq advances on every frame so one corrupted
               // frame does not desynchronise the following ones.
               next_exp_seq_s = exp_seq_r + 8'd1;
               frame_inc_s    = 1'b1;
               next_gap_s     = '0;
               if (good_s) begin
                  next_bad_run_s = '0;
               end else begin
                  err_inc_s = 1'b1;
                  if (bad_inc_s >= UNLOCK_TGT) begin
                     next_state_s    = ST_HUNT;
                     lost_inc_s      = 1'b1;
                     next_bad_run_s  = '0;
                     next_good_run_s = '0;
                  end else begin
                     next_bad_run_s = bad_inc_s;
                  end
               end
            end else begin
               if (gap_r >= GAP_LAST) begin
                  next_state_s    = ST_HUNT;
                  lost_inc_s      = 1'b1;
                  next_gap_s      = '0;
                  next_bad_run_s  = '0;
                  next_good_run_s = '0;
               end else begin
                  next_gap_s = gap_r + TW'(1'b1);
               end
            end
         end
         default: begin
            next_state_s    = ST_HUNT;
            next_good_run_s = '0;
            next_bad_run_s  = '0;
            next_gap_s      = '0;
         end
      endcase
   end

   // State machine and sequence tracking registers.
   always_ff @(posedge clk160) begin
      if (reset) begin
         state_r    <= ST_HUNT;
         locked_r   <= 1'b0;
         exp_seq_r  <= 8'd0;
         good_run_r <= '0;
         bad_run_r  <= '0;
         gap_r      <= '0;
      end else begin
         state_r    <= next_state_s;
         locked_r   <= (next_state_s == ST_LOCKED);
         exp_seq_r  <= next_exp_seq_s;
         good_run_r <= next_good_run_s;
         bad_run_r  <= next_bad_run_s;
         gap_r      <= next_gap_s;
      end
   end

   // Saturating statistics counters; clear_cnt takes priority over counting.
   always_ff @(posedge clk160) begin
      if (reset) begin
         frame_cnt_r     <= 32'd0;
         err_cnt_r       <= 16'd0;
         lost_lock_cnt_r <= 8'd0;
      end else if (clear_cnt) begin
         frame_cnt_r     <= 32'd0;
         err_cnt_r       <= 16'd0;
         lost_lock_cnt_r <= 8'd0;
      end else begin
         if (frame_inc_s && (frame_cnt_r != 32'hFFFF_FFFF)) begin
            frame_cnt_r <= frame_cnt_r + 32'd1;
         end
         if (err_inc_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
         end
         if (lost_inc_s && (lost_lock_cnt_r != 8'hFF)) begin
            lost_lock_cnt_r <= lost_lock_cnt_r + 8'd1;
         end
      end
   end

   // Bad-frame pulse and capture of the offending sequence number.
   always_ff @(posedge clk160) begin
      if (reset) begin
         err_pulse_r    <= 1'b0;
         last_bad_seq_r <= 8'd0;
      end else begin
         err_pulse_r <= err_inc_s;
         if (err_inc_s) begin
            last_bad_seq_r <= seq_s;
         end
      end
   end

   assign state         = state_r;
   assign locked        = locked_r;
   assign frame_cnt     = frame_cnt_r;
   assign err_cnt       = err_cnt_r;
   assign lost_lock_cnt = lost_lock_cnt_r;
   assign err_pulse     = err_pulse_r;
   assign last_bad_seq  = last_bad_seq_r;

endmodule

// File: tb/tb_strip_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_strip_frame_checker
//
// Directed scoreboard bench for strip_frame_checker. Each stimulus cycle pushes
// the hand-computed register image expected after the following clock edge;
// a separate monitor pops one entry per cycle and compares every output.
// -----------------------------------------------------------------------------
module tb_strip_frame_checker;

   logic         clk160 = 1'b0;
   logic         reset;
   logic [103:0] frame_data;
   logic         frame_valid;
   logic         clear_cnt;
   logic [1:0]   state;
   logic         locked;
   logic [31:0]  frame_cnt;
   logic [15:0]  err_cnt;
   logic [7:0]   lost_lock_cnt;
   logic         err_pulse;
   logic [7:0]   last_bad_seq;

   localparam logic [1:0] H = 2'd0;
   localparam logic [1:0] S = 2'd1;
   localparam logic [1:0] L = 2'd2;

   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] fc;
      logic [15:0] ec;
      logic [7:0]  llc;
      logic        pulse;
      logic [7:0]  lbs;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   strip_frame_checker dut (
      .clk160        (clk160),
      .reset         (reset),
      .frame_data    (frame_data),
      .frame_valid   (frame_valid),
      .clear_cnt     (clear_cnt),
      .state         (state),
      .locked        (locked),
      .frame_cnt     (frame_cnt),
      .err_cnt       (err_cnt),
      .lost_lock_cnt (lost_lock_cnt),
      .err_pulse     (err_pulse),
      .last_bad_seq  (last_bad_seq)
   );

   always #5 clk160 = ~clk160;

   function automatic logic [103:0] mk(input logic [7:0] s);
      return {s, ~s, {11{s}}};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the image expected after the edge.
   task automatic cyc(input logic rst, input logic fv, input logic clr, input logic [103:0] d);
      @(negedge clk160);
      reset       = rst;
      frame_valid = fv;
      clear_cnt   = clr;
      frame_data  = d;
      exp_q.push_back(e);
      e.pulse = 1'b0;
   endtask

   task automatic frm(input logic [7:0] s);
      cyc(1'b0, 1'b1, 1'b0, mk(s));
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 104'd0);
   endtask

   // Monitor: one expectation per cycle, sampled 1 time unit after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk160);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("state",         {30'd0, state},          {30'd0, x.st});
            chk("locked",        {31'd0, locked},         {31'd0, (x.st == L)});
            chk("frame_cnt",     frame_cnt,               x.fc);
            chk("err_cnt",       {16'd0, err_cnt},        {16'd0, x.ec});
            chk("lost_lock_cnt", {24'd0, lost_lock_cnt},  {24'd0, x.llc});
            chk("err_pulse",     {31'd0, err_pulse},      {31'd0, x.pulse});
            chk("last_bad_seq",  {24'd0, last_bad_seq},   {24'd0, x.lbs});
         end
      end
   end

   initial begin
      logic [103:0] d;
      reset       = 1'b1;
      frame_valid = 1'b0;
      clear_cnt   = 1'b0;
      frame_data  = 104'd0;
      e           = '0;

      // Reset, including reset overriding frame_valid and clear_cnt.
      cyc(1'b1, 1'b0, 1'b0, 104'd0);
      cyc(1'b1, 1'b1, 1'b1, mk(8'h10));

      // Malformed frame in HUNT is ignored.
      d = mk(8'h05);
      d[88] = ~d[88];
      cyc(1'b0, 1'b1, 1'b0, d);

      // Lock on 0x10..0x13; first counted frame is 0x14.
      e.st = S;
      frm(8'h10);
      frm(8'h11);
      frm(8'h12);
      e.st = L;
      frm(8'h13);
      e.fc = 32'd1;
      frm(8'h14);

      // Good stream then a payload-bit-0 error at seq 0x22.
      for (int i = 'h15; i <= 'h21; i++) begin
         e.fc = e.fc + 32'd1;
         frm(8'(i));
      end
      d = mk(8'h22);
      d[0] = ~d[0];
      e.fc = 32'd15;
      e.ec = 16'd1;
      e.pulse = 1'b1;
      e.lbs = 8'h22;
      cyc(1'b0, 1'b1, 1'b0, d);

      // 63-cycle gap keeps lock.
      repeat (63) idle();
      e.fc = 32'd16;
      frm(8'h23);

      // Clear, then three wrong-seq frames unlock.
      e.fc = 32'd0;
      e.ec = 16'd0;
      e.llc = 8'd0;
      cyc(1'b0, 1'b0, 1'b1, 104'd0);
      for (int i = 0; i < 3; i++) begin
         e.fc = e.fc + 32'd1;
         e.ec = e.ec + 16'd1;
         e.pulse = 1'b1;
         e.lbs = 8'(8'h50 + i);
         if (i == 2) begin
            e.st = H;
            e.llc = 8'd1;
         end
         frm(8'(8'h50 + i));
      end

      // Sequence break in SYNC drops to HUNT without a lost-lock count.
      e.st = S;
      frm(8'hFA);
      frm(8'hFB);
      e.st = H;
      frm(8'h70);

      // Relock near the top of the sequence space and wrap through 0x00.
      e.st = S;
      frm(8'hFA);
      frm(8'hFB);
      frm(8'hFC);
      e.st = L;
      frm(8'hFD);
      e.fc = 32'd4; frm(8'hFE);
      e.fc = 32'd5; frm(8'hFF);
      e.fc = 32'd6; frm(8'h00);
      e.fc = 32'd7; frm(8'h01);

      // Timeout: 64 empty cycles (first one also clears counters).
      e.fc = 32'd0;
      e.ec = 16'd0;
      e.llc = 8'd0;
      cyc(1'b0, 1'b0, 1'b1, 104'd0);
      repeat (62) idle();
      e.st = H;
      e.llc = 8'd1;
      idle();
      idle();

      // Saturation of err_cnt, then clear winning over an increment.
      e.st = S;
      frm(8'h30);
      frm(8'h31);
      frm(8'h32);
      e.st = L;
      frm(8'h33);
      e.ec = 16'hFFFF;
      idle();
      force dut.err_cnt_r = 16'hFFFF;
      #1;
      release dut.err_cnt_r;
      e.fc = 32'd1;
      e.pulse = 1'b1;
      e.lbs = 8'h99;
      frm(8'h99);
      e.fc = 32'd0;
      e.ec = 16'd0;
      e.llc = 8'd0;
      e.pulse = 1'b1;
      e.lbs = 8'h98;
      cyc(1'b0, 1'b1, 1'b1, mk(8'h98));
      idle();

      // Reset mid-stream; relock needs a full fresh run and bad_run restarts.
      e = '0;
      cyc(1'b1, 1'b1, 1'b0, mk(8'h35));
      e.st = S;
      frm(8'h40);
      frm(8'h41);
      frm(8'h42);
      e.st = L;
      frm(8'h43);
      e.fc = 32'd1;
      frm(8'h44);
      e.fc = 32'd2;
      e.ec = 16'd1;
      e.pulse = 1'b1;
      e.lbs = 8'h77;
      frm(8'h77);
      idle();

      stim_done = 1'b1;
      repeat (4) @(posedge clk160);
      #2;
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
